// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: 32-cycle shift-add multiply, restoring divide, register-file writeback.
// Define MUL_DIV_UNIT_DIV_EN to build the divider; without it funct3 4..7 complete normally with result 0.
//
// state | meaning
// IDLE  | waiting for start; operands and op latched on accept
// CALC  | 32 iterations, then one cycle to sign-correct and register the result
// DONE  | valid strobe for one cycle
module mul_div_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic [4:0]  rd,
   output logic        busy,
   output logic        valid,
   output logic [31:0] result,
   output logic [4:0]  rd_out,
   output logic        wb_we
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic        fin;
   logic [2:0]  op;
   logic [4:0]  rd_l;
   logic [31:0] opd;
   logic [63:0] acc;
   logic        neg_q;

   logic        is_div, sgn_a, sgn_b, neg_a, neg_b;
   logic [31:0] mag_a, mag_b;
   logic [32:0] sum33;
   logic [63:0] mul_nxt, step, prod_s;
   logic [31:0] mul_res, div_res, fin_res;

   // Both operations run on magnitudes; signs are restored in the finishing cycle.
   always_comb begin
      is_div = funct3[2];
      sgn_a  = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
      sgn_b  = funct3 inside {3'd0, 3'd1, 3'd4, 3'd6};
      neg_a  = sgn_a & rs1_val[31];
      neg_b  = sgn_b & rs2_val[31];
      mag_a  = neg_a ? -rs1_val : rs1_val;
      mag_b  = neg_b ? -rs2_val : rs2_val;
   end

   // acc = {partial product, multiplier}: add multiplicand into the high half, shift right.
   always_comb begin
      sum33   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
      mul_nxt = {sum33, acc[31:1]};
      prod_s  = neg_q ? -acc : acc;
      mul_res = (op == 3'd0) ? prod_s[31:0] : prod_s[63:32];
   end

`ifdef MUL_DIV_UNIT_DIV_EN
   logic [31:0] a_raw;
   logic        b_zero, neg_r;
   logic [32:0] r33;
   logic [33:0] trial;
   logic [63:0] div_nxt;
   logic [31:0] quo, rem;

   // acc = {remainder, dividend/quotient}: shift left, trial-subtract, restore on borrow.
   always_comb begin
      r33     = {acc[63:32], acc[31]};
      trial   = {1'b0, r33} - {2'b00, opd};
      div_nxt = trial[33] ? {r33[31:0], acc[30:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
      quo     = b_zero ? 32'hFFFF_FFFF : (neg_q ? -acc[31:0] : acc[31:0]);
      rem     = b_zero ? a_raw : (neg_r ? -acc[63:32] : acc[63:32]);
      div_res = op[1] ? rem : quo;
      step    = op[2] ? div_nxt : mul_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_raw  <= '0;
         b_zero <= 1'b0;
         neg_r  <= 1'b0;
      end else if (state == IDLE && start) begin
         a_raw  <= rs1_val;
         b_zero <= (rs2_val == 32'd0);
         neg_r  <= neg_a;
      end
   end
`else
   always_comb begin
      div_res = 32'd0;
      step    = mul_nxt;
   end
`endif

   always_comb fin_res = op[2] ? div_res : mul_res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (fin) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         fin    <= 1'b0;
         op     <= '0;
         rd_l   <= '0;
         opd    <= '0;
         acc    <= '0;
         neg_q  <= 1'b0;
         result <= '0;
         rd_out <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               op    <= funct3;
               rd_l  <= rd;
               opd   <= is_div ? mag_b : mag_a;
               acc   <= {32'd0, is_div ? mag_a : mag_b};
               neg_q <= neg_a ^ neg_b;
               cnt   <= '0;
               fin   <= 1'b0;
            end
            CALC: if (!fin) begin
               acc <= step;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) fin <= 1'b1;
            end else begin
               result <= fin_res;
               rd_out <= rd_l;
            end
            default: ;
         endcase
      end
   end

   assign busy  = (state == CALC) || (state == DONE);
   assign valid = (state == DONE);
   assign wb_we = valid && (rd_out != 5'd0);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit; expectations follow MUL_DIV_UNIT_DIV_EN when defined.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] rs1_val = '0;
   logic [31:0] rs2_val = '0;
   logic [4:0]  rd = '0;
   logic        busy, valid, wb_we;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int n_vec = 0;
   int n_err = 0;

`ifdef MUL_DIV_UNIT_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   mul_div_unit dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .funct3  (funct3),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .rd      (rd),
      .busy    (busy),
      .valid   (valid),
      .result  (result),
      .rd_out  (rd_out),
      .wb_we   (wb_we)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dexp(input logic [31:0] v);
      return DIV_EN ? v : 32'd0;
   endfunction

   // Called #1 after a clock edge; returns #1 after the edge following the valid cycle.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp);
      int acc_n;
      int n;
      funct3 = f; rs1_val = a; rs2_val = b; rd = r; start = 1'b1;
      acc_n = 0;
      do begin
         @(posedge clk); #1; acc_n++;
      end while (!busy && acc_n < 4);
      start = 1'b0; funct3 = ~f; rs1_val = ~a; rs2_val = ~b; rd = ~r;
      chk({tag, " accept"}, acc_n, 1);
      n = 0;
      while (!valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, " latency"}, n, 33);
      chk({tag, " result"}, result, exp);
      chk({tag, " rd_out"}, rd_out, r);
      chk({tag, " wb_we"}, wb_we, (r != 5'd0));
      @(posedge clk); #1;
      chk({tag, " valid drop"}, valid, 1'b0);
   endtask

   initial begin
      int nv;
      #12;
      chk("rst busy", busy, 1'b0);
      chk("rst valid", valid, 1'b0);
      chk("rst result", result, 32'd0);
      chk("rst rd_out", rd_out, 5'd0);
      chk("rst wb_we", wb_we, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      #1;

      run_op("mul neg",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
      run_op("mulhu -1",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE);
      run_op("mulh -1",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000);
      run_op("mulhsu -1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF);
      run_op("mul shift",  3'd0, 32'h1234_5678, 32'h0000_0010, 5'd9,  32'h2345_6780);
      run_op("mulh min",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000);
      run_op("div -7/2",   3'd4, 32'hFFFF_FFF9, 32'd2,         5'd11, dexp(32'hFFFF_FFFD));
      run_op("rem -7/2",   3'd6, 32'hFFFF_FFF9, 32'd2,         5'd12, dexp(32'hFFFF_FFFF));
      run_op("div ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, dexp(32'h8000_0000));
      run_op("rem ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0);
      run_op("divu /0",    3'd5, 32'd100,       32'd0,         5'd15, dexp(32'hFFFF_FFFF));
      run_op("remu /0",    3'd7, 32'd100,       32'd0,         5'd16, dexp(32'd100));
      run_op("div -7/0",   3'd4, 32'hFFFF_FFF9, 32'd0,         5'd17, dexp(32'hFFFF_FFFF));
      run_op("rem -7/0",   3'd6, 32'hFFFF_FFF9, 32'd0,         5'd18, dexp(32'hFFFF_FFF9));
      run_op("divu big",   3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 5'd19, dexp(32'h0FFF_FFFF));
      run_op("remu big",   3'd7, 32'hFFFF_FFFF, 32'h0000_0010, 5'd20, dexp(32'h0000_000F));
      run_op("rd zero",    3'd0, 32'd6,         32'd9,         5'd0,  32'd54);

      // start while busy must be dropped, not queued
      funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd5; rd = 5'd1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(posedge clk);
      #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      nv = 0;
      repeat (45) begin
         @(posedge clk); #1;
         if (valid) nv++;
      end
      chk("busy start valids", nv, 1);
      chk("busy start result", result, 32'd15);
      chk("busy start idle", busy, 1'b0);

      // abort mid-operation with reset
      funct3 = 3'd0; rs1_val = 32'd11; rs2_val = 32'd13; rd = 5'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) @(posedge clk);
      @(posedge clk); #2; rst_n = 1'b0;
      #1;
      chk("abort busy", busy, 1'b0);
      chk("abort valid", valid, 1'b0);
      chk("abort result", result, 32'd0);
      chk("abort rd_out", rd_out, 5'd0);
      @(negedge clk); rst_n = 1'b1;
      nv = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (valid) nv++;
      end
      chk("abort no valid", nv, 0);
      run_op("after abort", 3'd0, 32'd11, 32'd13, 5'd4, 32'd143);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
